// File: rtl/seq_sched_pkg.sv
// Shared types and defaults for the LED sequencing controller and the board
// tops that reuse its reset synchroniser.
package seq_sched_pkg;

  typedef enum logic [1:0] {
    ST_PAUSE = 2'd0,
    ST_RUN   = 2'd1,
    ST_LOAD  = 2'd2,
    ST_GUARD = 2'd3
  } state_e;

  localparam int RATE_W_DEF     = 3;
  localparam int LOAD_GUARD_DEF = 2;

endpackage

// File: rtl/seq_sched_if.sv
// Request/strobe bundle between the button filters + prescaler (master side)
// and the sequencing controller (slave side).
interface seq_sched_if #(
  parameter int RATE_W = seq_sched_pkg::RATE_W_DEF
) ();

  logic              tick;
  logic              step_req;
  logic              load_req;
  logic              run_req;
  logic [RATE_W-1:0] rate;
  logic              fsm_ce;
  logic              fsm_load;
  logic              running;
  logic              busy;

  modport master (
    output tick, step_req, load_req, run_req, rate,
    input  fsm_ce, fsm_load, running, busy
  );

  modport slave (
    input  tick, step_req, load_req, run_req, rate,
    output fsm_ce, fsm_load, running, busy
  );

endinterface

// File: rtl/seq_sched_reset_sync.sv
// Two-flop reset synchroniser: asserts asynchronously with rst_n low,
// releases on the second rising clk after rst_n returns high.
module reset_sync (
  input  logic clk,
  input  logic rst_n,
  output logic rst_out
);

  logic [1:0] sync_d;
  logic [1:0] sync_q;

  always_comb begin
    sync_d = {sync_q[0], 1'b0};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= sync_d;
  end

  assign rst_out = sync_q[1];

endmodule

// File: rtl/seq_sched.sv
// Sequencing controller: owns the board reset, arbitrates step/load/run
// requests and emits mutually exclusive ce/load strobes for the sequence FSM.
module seq_sched
  import seq_sched_pkg::*;
#(
  parameter int RATE_W     = RATE_W_DEF,
  parameter int LOAD_GUARD = LOAD_GUARD_DEF
) (
  input  logic         clk,
  input  logic         CPU_RESET,
  output logic         rst_out,
  seq_sched_if.slave   bus
);

  localparam int CNT_W   = (2 ** RATE_W) - 1;
  localparam int GUARD_W = (LOAD_GUARD > 1) ? $clog2(LOAD_GUARD) : 1;
  localparam logic [CNT_W:0] ONE = 1;

  state_e             state_d, state_q;
  logic               ret_run_d, ret_run_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic [GUARD_W-1:0] guard_d, guard_q;
  logic               fsm_ce_d, fsm_ce_q;
  logic               fsm_load_d, fsm_load_q;
  logic               running_d, running_q;
  logic               busy_d, busy_q;
  logic [CNT_W:0]     thr_w;

  reset_sync u_reset_sync (
    .clk     (clk),
    .rst_n   (CPU_RESET),
    .rst_out (rst_out)
  );

  // Auto-step threshold 2^rate-1; one extra bit holds 2^rate before the subtract.
  assign thr_w = (ONE << bus.rate) - ONE;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    ret_run_d = ret_run_q;
    cnt_d     = cnt_q;
    guard_d   = guard_q;
    fsm_ce_d  = 1'b0;

    unique case (state_q)
      ST_PAUSE: begin
        if (bus.load_req) begin
          state_d   = ST_LOAD;
          ret_run_d = 1'b0;
        end else if (bus.run_req) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (bus.step_req) begin
          fsm_ce_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.load_req) begin
          state_d   = ST_LOAD;
          ret_run_d = 1'b1;
        end else if (bus.run_req) begin
          state_d = ST_PAUSE;
        end else if (bus.tick) begin
          // >= rather than == so a rate lowered mid-count fires on the next tick.
          if (cnt_q >= thr_w[CNT_W-1:0]) begin
            fsm_ce_d = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_LOAD: begin
        state_d = ST_GUARD;
        guard_d = GUARD_W'(LOAD_GUARD - 1);
      end
      ST_GUARD: begin
        if (guard_q == '0) begin
          state_d = ret_run_q ? ST_RUN : ST_PAUSE;
          cnt_d   = '0;
        end else begin
          guard_d = guard_q - GUARD_W'(1);
        end
      end
      default: state_d = ST_PAUSE;
    endcase

    fsm_load_d = (state_d == ST_LOAD);
    running_d  = (state_d == ST_RUN);
    busy_d     = (state_d == ST_LOAD) || (state_d == ST_GUARD);
  end

  // Internal logic follows rst_out, so a CPU_RESET mid-load aborts at once.
  always_ff @(posedge clk or posedge rst_out) begin
    if (rst_out) begin
      state_q    <= ST_PAUSE;
      ret_run_q  <= 1'b0;
      cnt_q      <= '0;
      guard_q    <= '0;
      fsm_ce_q   <= 1'b0;
      fsm_load_q <= 1'b0;
      running_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_run_q  <= ret_run_d;
      cnt_q      <= cnt_d;
      guard_q    <= guard_d;
      fsm_ce_q   <= fsm_ce_d;
      fsm_load_q <= fsm_load_d;
      running_q  <= running_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.fsm_ce   = fsm_ce_q;
  assign bus.fsm_load = fsm_load_q;
  assign bus.running  = running_q;
  assign bus.busy     = busy_q;

endmodule

// File: doc/seq_sched.md
# seq_sched

Sequencing controller between the button filters / prescaler and the LED sequence FSM. Owns the board reset (synchronised `rst_out` for every downstream block), arbitrates manual step, load and automatic run requests, and emits the FSM's `ce`/`load` strobes, never both in one cycle. Adds a run/pause auto-step mode whose period is a power-of-two number of prescaler ticks.

## Interface
- `RATE_W`, 3, width of `rate`; auto period up to 2^(2^RATE_W−1) ticks
- `LOAD_GUARD`, 2, cycles (≥1) of suppressed `fsm_ce` after a load
- `clk` in 1: system clock
- `CPU_RESET` in 1: reset, asynchronous, active-low
- `tick` in 1: prescaler CE pulse (one cycle)
- `step_req` in 1: filtered one-cycle step pulse
- `load_req` in 1: filtered one-cycle load pulse
- `run_req` in 1: one-cycle run/pause toggle pulse
- `rate` in RATE_W: auto-step period = 2^rate ticks
- `rst_out` out 1: synchronised active-high reset for prescaler, filters, FSM
- `fsm_ce` out 1: one-cycle FSM advance strobe
- `fsm_load` out 1: one-cycle FSM load strobe
- `running` out 1: 1 = auto mode active
- `busy` out 1: 1 while in LOAD or GUARD

## Operation
- States: PAUSE, RUN, LOAD, GUARD. Reset → PAUSE. Internal logic reset by `rst_out`.
- Separate `ret_run` bit records which mode to resume after a load.
- PAUSE: `load_req` → LOAD (ret_run=0); else `run_req` → RUN; else `step_req` → one `fsm_ce`, stay.
- RUN: `load_req` → LOAD (ret_run=1); else `run_req` → PAUSE; `step_req` ignored; auto step as below.
- LOAD: `fsm_load`=1 for exactly one cycle, then GUARD.
- GUARD: counts LOAD_GUARD cycles, `fsm_ce`=0, all requests ignored (dropped, not queued); then → RUN if ret_run else PAUSE.
- Priority per cycle: load > run toggle > step/auto. `fsm_ce` and `fsm_load` mutually exclusive by construction.
- Auto step: tick counter, width 2^RATE_W−1 bits, increments on `tick` only in RUN. When `tick` and count ≥ 2^rate−1: `fsm_ce` pulse, count←0. `≥` compare so a lowered `rate` mid-count fires on the next tick. rate=0 → step every tick.
- Counter cleared on entry to RUN and on every exit from GUARD.
- Auto step in same cycle as `run_req` or `load_req`: suppressed.
- `running` = (state==RUN); `busy` = (state∈{LOAD,GUARD}).

## Timing
- `rst_out`: asserted asynchronously when CPU_RESET low; deasserted on the 2nd rising `clk` after CPU_RESET high (2-flop synchroniser).
- Reset values: `rst_out`=1, `fsm_ce`=0, `fsm_load`=0, `running`=0, `busy`=0, counter 0, ret_run 0.
- All outputs registered. Request in cycle n → strobe in cycle n+1, width exactly one cycle.
- `load_req` at n: `fsm_load`, `busy` at n+1; GUARD n+2…n+1+LOAD_GUARD; resumed state at n+2+LOAD_GUARD.
- `run_req` at n: `running` changes at n+1; first auto `fsm_ce` no earlier than 2^rate ticks after n.
- CPU_RESET mid-LOAD/GUARD: immediate abort, outputs to reset values, PAUSE after release.

## Structure
- Shared package/include `seq_sched_pkg`: state encodings (PAUSE=0, RUN=1, LOAD=2, GUARD=3), default RATE_W, LOAD_GUARD.
- One sub-module: `reset_sync` (2-flop async-assert/sync-deassert), reused by later board tops.
- Top-level replaces the ad-hoc reset register; `fsm_ce`/`fsm_load` feed the sequence FSM `ce`/`load`.

## Test plan
- CPU_RESET low 5 cycles, release → `rst_out` high throughout, low exactly 2 edges after release; all other outputs 0, state PAUSE.
- PAUSE, `step_req` at n → `fsm_ce` high at n+1 only; `step_req`+`run_req` same cycle → `running`=1, no `fsm_ce`.
- RUN, rate=2, `tick` every 4 cycles → `fsm_ce` once per 4 ticks; change rate 3→0 with count=5 → `fsm_ce` on next tick.
- RUN, `load_req` at n with LOAD_GUARD=2 → `fsm_load` at n+1, `busy` n+1..n+3, no `fsm_ce` in n+1..n+3, `running`=1 at n+4, counter 0.
- `load_req` and `run_req` same cycle in PAUSE → load taken, returns to PAUSE; `step_req` during GUARD → dropped.
- CPU_RESET asserted during GUARD → outputs reset asynchronously, PAUSE after release, no stray strobe.
